// File: rtl/store_buffer_if.sv
// Signal bundle shared by the MEM stage, the posted-store buffer and the data-memory port.
// The master side is the pipeline plus memory model; the slave side is the buffer.
interface store_buffer_if;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_ready;

  logic        ld_valid;
  logic [63:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [63:0] ld_data;
  logic        ld_stall;

  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;

  modport master (
    output st_valid, st_addr, st_data, st_funct3,
    input  st_ready,
    output ld_valid, ld_addr, ld_funct3,
    input  ld_data, ld_stall,
    input  mem_addr, mem_wdata, mem_funct3, mem_write, mem_read,
    output mem_rdata
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3,
    output st_ready,
    input  ld_valid, ld_addr, ld_funct3,
    output ld_data, ld_stall,
    output mem_addr, mem_wdata, mem_funct3, mem_write, mem_read,
    input  mem_rdata
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM and data memory: drains one store per idle port cycle,
// forwards exact load hits, stalls partial overlaps and lets misses own the port.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CNT_W = PTR_W + 1;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;

  function automatic logic [64:0] size_of(input logic [2:0] f3);
    return (f3 == F3_D) ? 65'd8 : 65'd4;
  endfunction

  logic [63:0]      r_ent_addr [DEPTH];
  logic [63:0]      r_ent_data [DEPTH];
  logic [2:0]       r_ent_f3   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_ready;
  logic             w_st_ok;
  logic             w_enq;
  logic             w_drain;
  logic             w_miss;
  logic             w_hit;
  logic             w_conflict;
  logic             w_any;
  logic [PTR_W-1:0] w_sel;
  logic [PTR_W-1:0] w_best_age;
  logic [PTR_W-1:0] w_age [DEPTH];
  logic [DEPTH-1:0] w_ovl;
  logic [64:0]      w_ld_end;

  // No pass-through: a slot freed by this cycle's drain is only usable next cycle.
  assign w_ready      = (r_count != CNT_W'(DEPTH));
  assign bus.st_ready = w_ready;
  assign w_st_ok      = (bus.st_funct3 == F3_W) || (bus.st_funct3 == F3_D);
  assign w_enq        = !reset && bus.st_valid && w_ready && w_st_ok;

  // Byte ranges use a 65-bit end so addresses near the top of the map do not wrap.
  assign w_ld_end = {1'b0, bus.ld_addr} + size_of(bus.ld_funct3);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [64:0] w_ent_end;
      assign w_age[gi]  = PTR_W'(gi) - r_head;
      assign w_ent_end  = {1'b0, r_ent_addr[gi]} + size_of(r_ent_f3[gi]);
      assign w_ovl[gi]  = ({1'b0, w_age[gi]} < r_count)
                        && ({1'b0, r_ent_addr[gi]} < w_ld_end)
                        && ({1'b0, bus.ld_addr} < w_ent_end);
    end
  endgenerate

  // Youngest overlapping entry (largest distance from head) decides the load class.
  always_comb begin
    w_any      = 1'b0;
    w_sel      = r_head;
    w_best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ovl[i] && (!w_any || (w_age[i] > w_best_age))) begin
        w_any      = 1'b1;
        w_sel      = PTR_W'(i);
        w_best_age = w_age[i];
      end
    end
  end

  assign w_hit      = bus.ld_valid && w_any
                    && (r_ent_addr[w_sel] == bus.ld_addr)
                    && (size_of(r_ent_f3[w_sel]) >= size_of(bus.ld_funct3));
  assign w_conflict = bus.ld_valid && w_any && !w_hit;
  assign w_miss     = bus.ld_valid && !w_any;
  assign w_drain    = !reset && (r_count != '0) && !w_miss;

  always_comb begin
    bus.ld_data    = '0;
    bus.ld_stall   = w_conflict;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_funct3 = '0;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    if (w_hit) begin
      bus.ld_data = (bus.ld_funct3 == F3_D) ? r_ent_data[w_sel]
                                             : {32'd0, r_ent_data[w_sel][31:0]};
    end else if (w_miss) begin
      bus.ld_data = bus.mem_rdata;
    end
    if (w_miss) begin
      bus.mem_read   = 1'b1;
      bus.mem_addr   = bus.ld_addr;
      bus.mem_funct3 = bus.ld_funct3;
    end else if (w_drain) begin
      bus.mem_write  = 1'b1;
      bus.mem_addr   = r_ent_addr[r_head];
      bus.mem_wdata  = r_ent_data[r_head];
      bus.mem_funct3 = r_ent_f3[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Word stores keep only their low half so the drained write data is clean.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_ent_addr[r_tail] <= bus.st_addr;
      r_ent_data[r_tail] <= (bus.st_funct3 == F3_D) ? bus.st_data
                                                     : {32'd0, bus.st_data[31:0]};
      r_ent_f3[r_tail]   <= bus.st_funct3;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed plus random stimulus for store_buffer, checked against a queue-based model
// of the posted stores and a fixed address-derived memory read pattern.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  store_buffer_if bif ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'hC3C3_3C3C};
  endfunction

  assign bif.mem_rdata = mem_model(bif.mem_addr);

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [2:0]  f3;
  } ent_t;

  ent_t        q[$];
  logic [63:0] wr_log[$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          exp_enq, exp_drain, exp_miss, exp_hit, exp_conflict;

  function automatic int size_of(input logic [2:0] f3);
    return (f3 == 3'b011) ? 8 : 4;
  endfunction

  function automatic bit overlaps(input logic [63:0] a, input int sa,
                                  input logic [63:0] b, input int sb);
    logic [64:0] ae, be;
    ae = {1'b0, a} + 65'(sa);
    be = {1'b0, b} + 65'(sb);
    return ({1'b0, a} < be) && ({1'b0, b} < ae);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_idle();
    bif.st_valid  = 1'b0;
    bif.st_addr   = '0;
    bif.st_data   = '0;
    bif.st_funct3 = 3'b000;
    bif.ld_valid  = 1'b0;
    bif.ld_addr   = '0;
    bif.ld_funct3 = 3'b010;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] f3);
    bif.st_valid  = 1'b1;
    bif.st_addr   = a;
    bif.st_data   = d;
    bif.st_funct3 = f3;
  endtask

  task automatic load(input logic [63:0] a, input logic [2:0] f3);
    bif.ld_valid  = 1'b1;
    bif.ld_addr   = a;
    bif.ld_funct3 = f3;
  endtask

  // Let inputs settle, derive the expected outputs from the model and compare.
  task automatic settle();
    int          newest;
    bit          exp_ready;
    logic [63:0] e_ld, e_addr, e_wdata;
    logic [2:0]  e_f3;
    bit          e_rd, e_wr;
    #2;
    exp_ready = (q.size() != DEPTH);
    newest    = -1;
    foreach (q[k]) begin
      if (overlaps(q[k].addr, size_of(q[k].f3), bif.ld_addr, size_of(bif.ld_funct3)))
        newest = k;
    end
    exp_hit = 1'b0;
    if (bif.ld_valid && newest >= 0)
      exp_hit = (q[newest].addr == bif.ld_addr)
              && (size_of(q[newest].f3) >= size_of(bif.ld_funct3));
    exp_miss     = bif.ld_valid && (newest < 0);
    exp_conflict = bif.ld_valid && (newest >= 0) && !exp_hit;
    exp_drain    = !reset && (q.size() != 0) && !exp_miss;
    exp_enq      = !reset && bif.st_valid && exp_ready
                 && (bif.st_funct3 == 3'b010 || bif.st_funct3 == 3'b011);
    e_ld = '0;
    if (exp_hit)
      e_ld = (bif.ld_funct3 == 3'b011) ? q[newest].data : {32'd0, q[newest].data[31:0]};
    else if (exp_miss)
      e_ld = mem_model(bif.ld_addr);
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_f3 = 3'b000;
    if (exp_miss) begin
      e_rd = 1'b1; e_addr = bif.ld_addr; e_f3 = bif.ld_funct3;
    end else if (exp_drain) begin
      e_wr = 1'b1; e_addr = q[0].addr; e_wdata = q[0].data; e_f3 = q[0].f3;
    end
    chk("st_ready",   64'(bif.st_ready),   64'(exp_ready));
    chk("ld_stall",   64'(bif.ld_stall),   64'(exp_conflict));
    chk("ld_data",    bif.ld_data,         e_ld);
    chk("mem_read",   64'(bif.mem_read),   64'(e_rd));
    chk("mem_write",  64'(bif.mem_write),  64'(e_wr));
    chk("mem_addr",   bif.mem_addr,        e_addr);
    chk("mem_wdata",  bif.mem_wdata,       e_wdata);
    chk("mem_funct3", 64'(bif.mem_funct3), 64'(e_f3));
    if (exp_drain) wr_log.push_back(bif.mem_addr);
    if (exp_enq || exp_drain || bif.ld_valid || reset)
      $display("t=%0t rst=%0b enq=%0b@%0h drain=%0b@%0h ld=%0b@%0h hit=%0b stall=%0b miss=%0b data=%h",
               $time, reset, exp_enq, bif.st_addr, exp_drain, bif.mem_addr,
               bif.ld_valid, bif.ld_addr, exp_hit, exp_conflict, exp_miss, bif.ld_data);
  endtask

  task automatic advance();
    ent_t e;
    e.addr = bif.st_addr;
    e.data = (bif.st_funct3 == 3'b011) ? bif.st_data : {32'd0, bif.st_data[31:0]};
    e.f3   = bif.st_funct3;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (exp_drain) void'(q.pop_front());
      if (exp_enq) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drain_all();
    set_idle();
    for (int c = 0; c < 20; c++) begin
      settle();
      if (q.size() == 0) break;
      advance();
    end
    chk("drained_idle_write", 64'(bif.mem_write), 64'(0));
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          stalls, n_acc, held;
    logic [63:0] exp_order [5];
    logic [2:0]  f3;
    exp_order = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd16};

    // Reset, including a store that must be discarded.
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    settle();
    chk("reset_ready", 64'(bif.st_ready), 64'(1));
    chk("reset_ld_data", bif.ld_data, 64'(0));
    advance();
    store(64'd8, 64'hDEAD_BEEF_0000_0008, 3'b010);
    step();
    reset = 1'b0;
    set_idle();
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("reset_store_dropped", 64'(bif.mem_write), 64'(0));
      advance();
    end

    // Doubleword store then word-load hit while the drain proceeds.
    store(64'd16, 64'h1122334455667788, 3'b011);
    step();
    set_idle();
    load(64'd16, 3'b010);
    settle();
    chk("hit_data", bif.ld_data, 64'h0000000055667788);
    chk("hit_stall", 64'(bif.ld_stall), 64'(0));
    chk("hit_drain_write", 64'(bif.mem_write), 64'(1));
    chk("hit_drain_addr", bif.mem_addr, 64'd16);
    advance();

    // Partial overlap stalls until the word drains, then becomes a miss.
    set_idle();
    store(64'd4, {$urandom, $urandom}, 3'b010);
    step();
    set_idle();
    load(64'd0, 3'b011);
    stalls = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (!exp_conflict) break;
      stalls++;
      chk("conflict_stall", 64'(bif.ld_stall), 64'(1));
      advance();
    end
    chk("conflict_cycles", 64'(stalls), 64'(1));
    chk("after_conflict_read", 64'(bif.mem_read), 64'(1));
    chk("after_conflict_addr", bif.mem_addr, 64'd0);
    advance();

    // Full buffer with a miss load holding the port.
    set_idle();
    wr_log.delete();
    load(64'd1000, 3'b011);
    n_acc = 0;
    held  = 0;
    for (int c = 0; c < 40 && n_acc < 5; c++) begin
      if (n_acc == 4 && held >= 2) bif.ld_valid = 1'b0;
      store(64'(4 * n_acc), {$urandom, $urandom}, 3'b010);
      settle();
      if (n_acc == 4 && bif.ld_valid) begin
        chk("full_ready_low", 64'(bif.st_ready), 64'(0));
        held++;
      end
      if (exp_enq) n_acc++;
      advance();
    end
    chk("full_all_accepted", 64'(n_acc), 64'(5));
    drain_all();
    chk("write_count", 64'(wr_log.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < wr_log.size()) chk("write_order", wr_log[i], exp_order[i]);
    end

    // Newest of two stores to the same word wins.
    load(64'd1000, 3'b011);
    store(64'd32, {$urandom, 32'hAAAAAAAA}, 3'b010);
    step();
    store(64'd32, {$urandom, 32'hBBBBBBBB}, 3'b010);
    step();
    bif.st_valid = 1'b0;
    load(64'd32, 3'b010);
    settle();
    chk("newest_wins", bif.ld_data, 64'h00000000BBBBBBBB);
    chk("newest_stall", 64'(bif.ld_stall), 64'(0));
    advance();
    drain_all();

    // Unsupported width is dropped.
    store(64'd40, {$urandom, $urandom}, 3'b000);
    step();
    set_idle();
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("invalid_no_write", 64'(bif.mem_write), 64'(0));
      advance();
    end

    // Reset in the middle of draining discards the rest.
    load(64'd1000, 3'b011);
    for (int i = 0; i < 3; i++) begin
      store(64'(64 + 8 * i), {$urandom, $urandom}, 3'b011);
      step();
    end
    set_idle();
    step();
    reset = 1'b1;
    store(64'd8, {$urandom, $urandom}, 3'b010);
    settle();
    chk("reset_mid_no_write", 64'(bif.mem_write), 64'(0));
    advance();
    reset = 1'b0;
    set_idle();
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("post_reset_no_write", 64'(bif.mem_write), 64'(0));
      chk("post_reset_ready", 64'(bif.st_ready), 64'(1));
      advance();
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_idle();
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: f3 = 3'b010;
          4, 5, 6, 7: f3 = 3'b011;
          default:    f3 = 3'($urandom_range(0, 7));
        endcase
        store(64'($urandom_range(0, 40)), {$urandom, $urandom}, f3);
      end
      if ($urandom_range(0, 2) == 0)
        load(64'($urandom_range(0, 44)), ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011);
      step();
    end
    reset = 1'b0;
    drain_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
